// File: rtl/mem_responder.sv
// Single-port word memory answering load/store requests over valid/ready channels,
// with programmable response latency. Optional exit register enabled by `MEM_RESP_EXIT_EN.
module mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] EXIT_ADDR   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        exit,
  output logic [2:0]  gp
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_WAIT    = 2'd1;
  localparam logic [1:0]  S_RESP    = 2'd2;
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             accept;
  logic             misaligned;
  logic             hit_exit;
  logic             out_range;
  logic             dec_err;
  logic             exit_sel;
  logic             hit_mem;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rdata_p0;
  logic             err_p0;
  logic             exit_q;
  logic [2:0]       gp_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Reset has priority: a request seen while rst is high is never taken.
  assign accept = (state == S_IDLE) && req_valid && !rst;

  assign misaligned = (req_addr[1:0] != 2'b00);
  assign hit_exit   = (req_addr == EXIT_ADDR);
  assign out_range  = ({1'b0, req_addr} >= MEM_BYTES);
  assign word_idx   = req_addr[IDX_W+1:2];

`ifdef MEM_RESP_EXIT_EN
  assign exit_sel = !misaligned && hit_exit;
  assign dec_err  = misaligned || (!hit_exit && out_range);
`else
  // Without the exit register its address is just another unmapped location.
  assign exit_sel = 1'b0;
  assign dec_err  = misaligned || hit_exit || out_range;
`endif

  assign hit_mem = !dec_err && !exit_sel;

  // Stage p0: accept edge commits stores and captures the response payload.
  always_ff @(posedge clk) begin
    if (accept && req_we && hit_mem) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (!req_we && hit_mem)       rdata_p0 <= mem[word_idx];
      else if (!req_we && exit_sel) rdata_p0 <= {29'b0, gp_q};
      else                          rdata_p0 <= '0;
      err_p0 <= dec_err;
    end
  end

`ifdef MEM_RESP_EXIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exit_q <= 1'b0;
      gp_q   <= 3'd0;
    end else if (accept && req_we && exit_sel) begin
      exit_q <= 1'b1;
      gp_q   <= req_wdata[2:0];
    end
  end
`else
  assign exit_q = 1'b0;
  assign gp_q   = 3'd0;
`endif

  assign exit = exit_q;
  assign gp   = gp_q;

  // Stage p1: wait-state sequencing and response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt <= 4'd1) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Payload registers carry no reset; gating by valid keeps the outputs clean.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = resp_valid ? rdata_p0 : 32'd0;
  assign resp_err   = resp_valid ? err_p0 : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected responses, immediate-assert checks.
module tb_mem_responder;

  localparam int          DEPTH  = 4096;
  localparam int          LAT    = 2;
  localparam logic [31:0] EXIT_A = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        exit;
  logic [2:0]  gp;

  int tests = 0;
  int fails = 0;

  logic [32:0] sb [$];
  logic [31:0] mm [logic [31:0]];
  logic        mexit = 1'b0;
  logic [2:0]  mgp = 3'd0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .EXIT_ADDR(EXIT_A)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .exit(exit), .gp(gp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference behaviour: decode, update model state, return {err, rdata}.
  function automatic logic [32:0] model(input logic we, input logic [31:0] a,
                                        input logic [31:0] w, input logic [3:0] s);
    logic        err;
    logic        ex;
    logic [31:0] r;
    logic [31:0] word;
    ex = 1'b0;
    r  = 32'd0;
`ifdef MEM_RESP_EXIT_EN
    ex = (a == EXIT_A);
`endif
    err = (a[1:0] != 2'b00) || (!ex && (a >= DEPTH * 4));
    if (!err && ex) begin
      if (we) begin
        mexit = 1'b1;
        mgp   = w[2:0];
      end else begin
        r = {29'b0, mgp};
      end
    end else if (!err) begin
      if (we) begin
        word = mm.exists(a) ? mm[a] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = w[8*b +: 8];
        mm[a] = word;
      end else begin
        r = mm.exists(a) ? mm[a] : 32'hxxxx_xxxx;
      end
    end
    return {err, r};
  endfunction

  task automatic pop_check(input string tag);
    logic [32:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 33'h1_5A5A_5A5A;
    check({tag, "_rdata"}, resp_rdata, e[31:0]);
    check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e[32]});
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] w, input logic [3:0] s, input int hold);
    int          n;
    logic [31:0] hr;
    logic        he;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = w;
    req_wstrb  = s;
    resp_ready = (hold == 0);
    sb.push_back(model(we, a, w, s));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
    hr = resp_rdata;
    he = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, hr);
      check({tag, "_hold_err"}, {31'b0, resp_err}, {31'b0, he});
      check({tag, "_hold_busy"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    pop_check(tag);
    @(negedge clk);
    check({tag, "_after_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_after_rdata"}, resp_rdata, 32'd0);
    check({tag, "_after_err"}, {31'b0, resp_err}, 32'd0);
    check({tag, "_after_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_exit"}, {31'b0, exit}, {31'b0, mexit});
    check({tag, "_gp"}, {29'b0, gp}, {29'b0, mgp});
  endtask

  // Issue a request, then reset while it waits; the store side effect must survive.
  task automatic reset_in_wait(input string tag, input logic we, input logic [31:0] a,
                               input logic [31:0] w);
    logic [32:0] unused_e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = w;
    req_wstrb = 4'hF;
    unused_e  = model(we, a, w, 4'hF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_in_wait"}, {31'b0, resp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    mexit = 1'b0;
    mgp   = 3'd0;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_exit"}, {31'b0, exit}, 32'd0);
    check({tag, "_gp"}, {29'b0, gp}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_dropped"}, {31'b0, resp_valid}, 32'd0);
    end
  endtask

  initial begin
    int acc;
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_wstrb  = 4'h0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_exit", {31'b0, exit}, 32'd0);
    check("rst_gp", {29'b0, gp}, 32'd0);

    xact("st40", 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 0);
    xact("ld40", 1'b0, 32'h40, 32'd0, 4'h0, 0);
    xact("st40_b0", 1'b1, 32'h40, 32'h0000_00AA, 4'b0001, 0);
    xact("ld40_b0", 1'b0, 32'h40, 32'd0, 4'h0, 0);
    xact("ld_mis", 1'b0, 32'h42, 32'd0, 4'h0, 0);
    xact("ld_oor", 1'b0, DEPTH * 4, 32'd0, 4'h0, 0);
    xact("ld40_chk", 1'b0, 32'h40, 32'd0, 4'h0, 0);
    xact("st48", 1'b1, 32'h48, 32'h0000_0000, 4'hF, 0);
    xact("st48_mix", 1'b1, 32'h48, 32'h1234_5678, 4'b1010, 0);
    xact("ld48", 1'b0, 32'h48, 32'd0, 4'h0, 0);
    xact("st44", 1'b1, 32'h44, 32'hCAFE_F00D, 4'hF, 0);
    xact("st44_nostrb", 1'b1, 32'h44, 32'h1111_1111, 4'h0, 0);
    xact("ld44", 1'b0, 32'h44, 32'd0, 4'h0, 0);
    xact("st_top", 1'b1, DEPTH * 4 - 4, 32'h0BAD_CAFE, 4'hF, 0);
    xact("ld_top", 1'b0, DEPTH * 4 - 4, 32'd0, 4'h0, 0);
    xact("st_mis", 1'b1, 32'h41, 32'hFFFF_FFFF, 4'hF, 0);
    xact("st_oor", 1'b1, DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 0);
    xact("ld40_hold", 1'b0, 32'h40, 32'd0, 4'h0, 5);

    xact("st_exit", 1'b1, EXIT_A, 32'h0000_0005, 4'hF, 0);
    xact("ld_exit", 1'b0, EXIT_A, 32'd0, 4'h0, 0);
    xact("st_exit2", 1'b1, EXIT_A, 32'h0000_0002, 4'hF, 0);
    xact("ld_exit2", 1'b0, EXIT_A, 32'd0, 4'h0, 0);

    reset_in_wait("rst_wait_ld", 1'b0, 32'h40, 32'd0);
    reset_in_wait("rst_wait_st", 1'b1, 32'h80, 32'h1122_3344);
    xact("ld80", 1'b0, 32'h80, 32'd0, 4'h0, 0);
    xact("ld40_post", 1'b0, 32'h40, 32'd0, 4'h0, 0);

    // Back-to-back loads with req_valid held and resp_ready tied high.
    acc        = 0;
    resp_ready = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h48;
    req_wstrb  = 4'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      if (resp_valid) pop_check("b2b");
      if (req_ready) begin
        sb.push_back(model(1'b0, 32'h48, 32'd0, 4'h0));
        acc++;
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) pop_check("b2b_drain");
      n++;
    end while (sb.size() > 0 && n < 30);
    check("b2b_drained", sb.size(), 32'd0);
    check("b2b_accepts", acc, (12 + LAT) / (LAT + 1));
    @(negedge clk);
    check("b2b_idle", {31'b0, req_ready}, 32'd1);
    check("b2b_novalid", {31'b0, resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
